// File: rtl/gray_frame_sequencer_if.sv
// Memory, converter and output-stream bundle for gray_frame_sequencer.
// master = sequencer side, slave = memory / converter / sink side.
interface gray_frame_sequencer_if #(
  parameter int ADDR_W = 20
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rd_data;
  logic [7:0]        conv_r;
  logic [7:0]        conv_g;
  logic [7:0]        conv_b;
  logic [7:0]        gray_in;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_data;
  logic              out_sof;
  logic              out_eol;
  logic              out_eof;

  modport master (
    output mem_rd_en, mem_addr,
    input  mem_rd_data,
    output conv_r, conv_g, conv_b,
    input  gray_in,
    output out_valid, out_data,
    output out_sof, out_eol, out_eof,
    input  out_ready
  );

  modport slave (
    input  mem_rd_en, mem_addr,
    output mem_rd_data,
    input  conv_r, conv_g, conv_b,
    output gray_in,
    input  out_valid, out_data,
    input  out_sof, out_eol, out_eof,
    output out_ready
  );
endinterface

// File: rtl/gray_frame_sequencer.sv
// Streams one packed RGB frame through an external grayscale
// converter and emits gray pixels with sof/eol/eof flags.
module gray_frame_sequencer #(
  parameter int WIDTH  = 512,
  parameter int HEIGHT = 512,
  parameter int ADDR_W = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic abort,
  output logic busy,
  output logic done,
  gray_frame_sequencer_if.master bus
);

  localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

  typedef enum logic [2:0] {
    IDLE, RD_R, RD_G, RD_B, CAP, CONV, OUT
  } state_t;

  state_t state, state_nx;

  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] addr;
  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [7:0]        r_q, g_q, b_q, data_q;
  logic              sof_q, eol_q, eof_q;
  logic              done_q;
  logic              rd_en;
  logic              valid;
  logic              go;
  logic              hs;

  assign go = (state == IDLE) && start && !abort;
  assign hs = (state == OUT) && bus.out_ready && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (go)            state_nx = RD_R;
      RD_R:                    state_nx = RD_G;
      RD_G:                    state_nx = RD_B;
      RD_B:                    state_nx = CAP;
      CAP:                     state_nx = CONV;
      CONV:                    state_nx = OUT;
      OUT:  if (bus.out_ready) state_nx = eof_q ? IDLE : RD_R;
      default:                 state_nx = IDLE;
    endcase
    if (abort) state_nx = IDLE;
  end

  always_comb begin
    busy  = (state != IDLE);
    rd_en = (state == RD_R) || (state == RD_G) ||
            (state == RD_B);
    valid = (state == OUT);
  end

  // mem_addr is registered so it holds while no read is in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base   <= '0;
      addr   <= '0;
      col    <= '0;
      row    <= '0;
      r_q    <= '0;
      g_q    <= '0;
      b_q    <= '0;
      data_q <= '0;
      sof_q  <= 1'b0;
      eol_q  <= 1'b0;
      eof_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= hs && eof_q;
      if (go) begin
        base <= '0;
        addr <= '0;
        col  <= '0;
        row  <= '0;
      end else if (!abort) begin
        unique case (state)
          RD_R: addr <= base + ADDR_W'(1);
          RD_G: begin
            addr <= base + ADDR_W'(2);
            r_q  <= bus.mem_rd_data;
          end
          RD_B: g_q <= bus.mem_rd_data;
          CAP:  b_q <= bus.mem_rd_data;
          CONV: begin
            data_q <= bus.gray_in;
            sof_q  <= (row == '0) && (col == '0);
            eol_q  <= (col == COL_LAST);
            eof_q  <= (col == COL_LAST) && (row == ROW_LAST);
          end
          OUT: if (bus.out_ready) begin
            base <= base + ADDR_W'(3);
            if (!eof_q) addr <= base + ADDR_W'(3);
            if (col == COL_LAST) begin
              col <= '0;
              row <= row + RW'(1);
            end else begin
              col <= col + CW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign done          = done_q;
  assign bus.mem_rd_en = rd_en;
  assign bus.mem_addr  = addr;
  assign bus.conv_r    = r_q;
  assign bus.conv_g    = g_q;
  assign bus.conv_b    = b_q;
  assign bus.out_valid = valid;
  assign bus.out_data  = data_q;
  assign bus.out_sof   = sof_q;
  assign bus.out_eol   = eol_q;
  assign bus.out_eof   = eof_q;

endmodule

// File: tb/tb_gray_frame_sequencer.sv
// Randomized scoreboard bench for gray_frame_sequencer on a
// 4x2 frame with a byte memory and behavioural grayscale converter.
module tb_gray_frame_sequencer;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int N  = W * H;
  localparam int AW = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic busy;
  logic done;

  gray_frame_sequencer_if #(.ADDR_W(AW)) bus ();

  gray_frame_sequencer #(
    .WIDTH (W),
    .HEIGHT(H),
    .ADDR_W(AW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .abort(abort),
    .busy (busy),
    .done (done),
    .bus  (bus.master)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gray_of(int r, int g, int b);
    return 8'((77 * r + 150 * g + 29 * b) >> 8);
  endfunction

  logic [7:0] mem [256];

  always @(posedge clk)
    if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_addr];

  assign bus.gray_in = gray_of(int'(bus.conv_r), int'(bus.conv_g),
                               int'(bus.conv_b));

  typedef struct {
    logic [7:0] d;
    bit         sof;
    bit         eol;
    bit         eof;
  } pix_t;

  pix_t exp_q[$];

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(bit ok, string nm, int act, int req);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)",
               nm, act, req, cyc);
    end
  endtask

  // monitor state
  int start_cyc = 0;
  int exp_addr  = 0;
  int stalls    = 0;
  int stall_pix = 0;
  int prev_hs   = -1;
  int done_at   = -1;
  int idle_at   = -1;
  int frames_done = 0;
  bit held = 1'b0;
  logic [10:0] hold_v = '0;

  function automatic logic [10:0] out_vec();
    return {bus.out_data, bus.out_sof, bus.out_eol, bus.out_eof};
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      done_at = -1;
      idle_at = -1;
      held    = 1'b0;
    end else begin
      if (done || cyc == done_at)
        chk(done == (cyc == done_at), "done_pulse",
            int'(done), int'(cyc == done_at));
      if (done)
        chk(!busy, "busy_low_on_done", int'(busy), 0);
      if (cyc == idle_at)
        chk(!busy && !bus.out_valid, "abort_to_idle",
            int'({busy, bus.out_valid}), 0);
      if (!busy && start && !abort) begin
        start_cyc = cyc;
        exp_addr  = 0;
        stalls    = 0;
        stall_pix = 0;
        prev_hs   = -1;
      end
      if (bus.mem_rd_en) begin
        chk(bus.mem_addr == AW'(exp_addr), "rd_addr",
            int'(bus.mem_addr), exp_addr);
        exp_addr++;
      end
      if (bus.out_valid) begin
        chk(!bus.mem_rd_en, "no_read_in_out", int'(bus.mem_rd_en), 0);
        if (held)
          chk(out_vec() == hold_v, "hold_stable",
              int'(out_vec()), int'(hold_v));
      end
      if (abort && busy) begin
        exp_q.delete();
        idle_at = cyc + 1;
        held    = 1'b0;
      end else if (bus.out_valid && !bus.out_ready) begin
        stalls++;
        stall_pix++;
        held   = 1'b1;
        hold_v = out_vec();
      end else if (bus.out_valid) begin
        held = 1'b0;
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_pixel", int'(bus.out_data), -1);
        end else begin
          pix_t e;
          e = exp_q.pop_front();
          chk(bus.out_data == e.d, "pixel_data",
              int'(bus.out_data), int'(e.d));
          chk({bus.out_sof, bus.out_eol, bus.out_eof} ==
              {e.sof, e.eol, e.eof}, "pixel_flags",
              int'({bus.out_sof, bus.out_eol, bus.out_eof}),
              int'({e.sof, e.eol, e.eof}));
        end
        if (prev_hs >= 0)
          chk(cyc - prev_hs == 6 + stall_pix, "hs_spacing",
              cyc - prev_hs, 6 + stall_pix);
        else
          chk(cyc - start_cyc == 6 + stall_pix, "first_latency",
              cyc - start_cyc, 6 + stall_pix);
        prev_hs   = cyc;
        stall_pix = 0;
        if (bus.out_eof) begin
          chk(cyc - start_cyc == 6 * N + stalls, "frame_cycles",
              cyc - start_cyc, 6 * N + stalls);
          done_at = cyc + 1;
          frames_done++;
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  function automatic logic [127:0] all_outs();
    return {busy, done, bus.mem_rd_en, bus.mem_addr,
            bus.conv_r, bus.conv_g, bus.conv_b, bus.out_valid,
            bus.out_data, bus.out_sof, bus.out_eol, bus.out_eof};
  endfunction

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_frame(bit rnd);
    for (int i = 0; i < 256; i++)
      mem[i] = rnd ? 8'($urandom) : 8'(i);
    for (int i = 0; i < N; i++) begin
      pix_t p;
      p.d   = gray_of(int'(mem[3*i]), int'(mem[3*i+1]),
                      int'(mem[3*i+2]));
      p.sof = (i == 0);
      p.eol = (i % W) == W - 1;
      p.eof = (i == N - 1);
      exp_q.push_back(p);
    end
  endtask

  task automatic issue_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  // rmode 0: ready high; 1: stall 5 cycles on pixel 2; 2: random
  task automatic run_frame(bit rnd, int rmode, bit busy_start);
    int pix = 0;
    int st  = 0;
    bit ok  = 1'b0;
    load_frame(rnd);
    issue_start();
    for (int k = 0; k < 400; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        ok = 1'b1;
        break;
      end
      start = busy_start && (k == 10);
      if (rmode == 1) begin
        if (bus.out_valid && pix == 2 && st < 5) begin
          bus.out_ready = 1'b0;
          st++;
        end else begin
          bus.out_ready = 1'b1;
        end
      end else if (rmode == 2) begin
        bus.out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        bus.out_ready = 1'b1;
      end
      if (bus.out_valid && bus.out_ready) pix++;
    end
    start = 1'b0;
    bus.out_ready = 1'b1;
    if (!ok) chk(1'b0, "frame_timeout", 0, 1);
    tick(2);
  endtask

  int exp_frames = 0;

  initial begin
    bus.out_ready = 1'b1;
    #1;
    chk(all_outs() == '0, "reset_values", int'(all_outs()), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    tick(2);

    run_frame(1'b0, 0, 1'b0);
    exp_frames++;
    run_frame(1'b0, 1, 1'b0);
    exp_frames++;
    for (int f = 0; f < 4; f++) begin
      run_frame(1'b1, 2, f == 1);
      exp_frames++;
    end

    // asynchronous reset while reading the blue byte
    load_frame(1'b0);
    issue_start();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.mem_rd_en && bus.mem_addr == AW'(2)) break;
    end
    #2 rst_n = 1'b0;
    #1 chk(all_outs() == '0, "async_reset", int'(all_outs()), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    tick(1);
    chk(!busy, "idle_after_reset", int'(busy), 0);
    run_frame(1'b0, 0, 1'b0);
    exp_frames++;

    // abort on the second output cycle with ready high
    load_frame(1'b1);
    issue_start();
    begin
      int seen = 0;
      for (int k = 0; k < 40; k++) begin
        if (bus.out_valid) begin
          if (seen == 1) break;
          seen++;
        end
        tick(1);
      end
      chk(bus.out_valid, "abort_reached_out", int'(bus.out_valid), 1);
    end
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    tick(10);
    run_frame(1'b0, 0, 1'b0);
    exp_frames++;

    // start together with abort in IDLE is ignored
    start = 1'b1;
    abort = 1'b1;
    tick(1);
    start = 1'b0;
    abort = 1'b0;
    tick(5);
    chk(!busy, "start_abort_idle", int'(busy), 0);
    run_frame(1'b1, 2, 1'b0);
    exp_frames++;

    tick(5);
    chk(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);
    chk(frames_done == exp_frames, "frame_count",
        frames_done, exp_frames);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/gray_frame_sequencer.md
# gray_frame_sequencer

Controller that streams one RGB frame out of a byte-wide pixel memory through the combinational `rgb_to_grayscale` converter and emits a grayscale pixel stream with valid/ready backpressure and frame-position flags. It sits between the RGB frame buffer, which is packed 3 bytes per pixel in R,G,B order and row-major, and the downstream edge-detection stages. It is the block that sequences the converter in hardware.

## Interface
- WIDTH, 512, pixels per row (≥2)
- HEIGHT, 512, rows per frame (≥1)
- ADDR_W, 20, memory byte-address width; must satisfy 2^ADDR_W ≥ WIDTH*HEIGHT*3
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low
- start  input  1  frame start request, sampled only in IDLE
- abort  input  1  stop current frame, return to IDLE, no done
- busy  output  1  high whenever state ≠ IDLE
- done  output  1  one-cycle pulse after the final pixel handshake
- mem_rd_en  output  1  memory read strobe
- mem_addr  output  ADDR_W  byte address
- mem_rd_data  input  8  read data, valid exactly 1 cycle after mem_rd_en
- conv_r, conv_g, conv_b  output  8 each  registered operands to rgb_to_grayscale
- gray_in  input  8  converter result (combinational from conv_r/g/b)
- out_valid  output  1  gray pixel available
- out_ready  input  1  downstream accepts
- out_data  output  8  gray pixel
- out_sof, out_eol, out_eof  output  1 each  first pixel of frame / last pixel of row / last pixel of frame; qualified by out_valid

## Operation
- States: IDLE, RD_R, RD_G, RD_B, CAP, CONV, OUT.
- IDLE: on start=1, clear pixel address base, row and col to 0, then go to RD_R. A start in any other state is ignored.
- RD_R: mem_rd_en=1, mem_addr=base. Go to RD_G.
- RD_G: mem_rd_en=1, mem_addr=base+1. Latch mem_rd_data into conv_r. Go to RD_B.
- RD_B: mem_rd_en=1, mem_addr=base+2. Latch into conv_g. Go to CAP.
- CAP: mem_rd_en=0. Latch into conv_b. Go to CONV.
- CONV: latch gray_in into out_data. Set out_sof=(row==0&&col==0), out_eol=(col==WIDTH-1), out_eof=(out_eol&&row==HEIGHT-1). Go to OUT.
- OUT: out_valid=1. out_data and the flags are held stable until out_valid&&out_ready.
  - On handshake: base+=3. col wraps WIDTH-1→0 and increments row.
  - If the pixel was eof: go to IDLE and pulse done. Otherwise go to RD_R.
- mem_addr holds its last value when mem_rd_en=0. Address arithmetic is modulo 2^ADDR_W; no overflow occurs for legal parameters.
- abort=1 in any non-IDLE state: go to IDLE at the next edge. out_valid drops, no done, outstanding read data is discarded. abort has priority over a simultaneous handshake.
- start and abort both high in IDLE: abort wins, stay IDLE.
- Reset (asynchronous, any time, including mid-frame): state=IDLE, and all outputs are 0:
  - busy, done, mem_rd_en, mem_addr
  - conv_r/g/b, out_valid, out_data, out_sof/eol/eof
  - the internal base, row and col counters are also cleared.

## Timing
- start sampled at edge E0: mem_rd_en=1 with addr 0 during E0–E1, addr 1 during E1–E2, addr 2 during E2–E3.
- conv_b is valid after E4. out_valid rises after E5.
- With out_ready held 1: each pixel handshake occurs 6 cycles after the previous one; a frame takes 6·WIDTH·HEIGHT cycles from E0 to the final handshake.
- done is high for exactly the one cycle following the final handshake edge, while busy=0 in that cycle.
- Backpressure: each cycle out_ready=0 in OUT adds one cycle. No memory reads are issued while in OUT.
- busy rises after E0 and falls at the edge of the final handshake or of abort.

## Test plan
- Reset values: assert rst_n=0 mid-frame (state RD_B) → all outputs 0 within the same cycle (asynchronous); after release, state is IDLE and start restarts from addr 0.
- Single frame, WIDTH=4, HEIGHT=2, memory bytes = index mod 256, out_ready=1 → addresses 0..23 read in order; 8 outputs, each equal to the reference model of gray(3i,3i+1,3i+2); handshakes 6 cycles apart; done 48 cycles after start.
- Flags, same setup → out_sof only on pixel 0; out_eol on pixels 3 and 7; out_eof only on pixel 7; done pulses once, 1 cycle wide.
- Backpressure: out_ready=0 for 5 cycles on pixel 2 → out_data and flags stable, mem_rd_en=0 throughout; pixel 3 read begins the cycle after the handshake; total frame time 53 cycles.
- Abort during OUT with out_ready=1 on the same cycle → no handshake counted, IDLE next cycle, done never asserted; a new start reads from addr 0.
- start pulsed while busy, and start+abort together in IDLE → both ignored; address sequence and output count unchanged.
